// File: rtl/operand_fetch_unit_pkg.sv
// operand_fetch_unit_pkg
//   Shared CPU constants and types for the operand-fetch stage and its
//   register scoreboard.
//   - NUM_REGS / REG_IDX_W : architectural register file size and index width
//   - DATA_W               : datapath width
//   - PC_IDX               : index of the PC register (R15); the fetch stage
//                            treats it as an ordinary register
//   - STALL_W              : width of the hazard-stall counter
package operand_fetch_unit_pkg;

   localparam int NUM_REGS  = 16;
   localparam int REG_IDX_W = 4;
   localparam int DATA_W    = 32;
   localparam int PC_IDX    = 15;
   localparam int STALL_W   = 16;

   // One operand bundle as handed to the execute stage.
   typedef struct packed {
      logic [DATA_W-1:0]    a;
      logic [DATA_W-1:0]    b;
      logic [DATA_W-1:0]    d;
      logic [REG_IDX_W-1:0] rd;
      logic                 wr;
   } out_item_t;

   // Operand select: a used source that is being written back this cycle
   // takes the writeback value instead of the (stale) register-file read.
   function automatic logic [DATA_W-1:0] bypass_sel(
      input logic                 use_src,
      input logic                 wb_hit,
      input logic [DATA_W-1:0]    wb_data,
      input logic [DATA_W-1:0]    rf_data
   );
      return (use_src && wb_hit) ? wb_data : rf_data;
   endfunction

endpackage

// File: rtl/operand_fetch_unit_reg_scoreboard.sv
// reg_scoreboard
//   One pending bit per architectural register. A bit is set when an
//   instruction that writes the register issues, and cleared when the
//   writeback for that register arrives. Set and clear in the same cycle on
//   the same register leave the bit set: the new writer is still outstanding.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     set_en / set_idx     : mark a register pending
//     clr_en / clr_idx     : writeback, clear pending
//     q_rn/q_rm/q_rs/q_rd  : query indices
//     pend_rn..pend_rd     : current pending state of the queried registers
module reg_scoreboard
   import operand_fetch_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en,
   input  logic [REG_IDX_W-1:0] set_idx,
   input  logic                 clr_en,
   input  logic [REG_IDX_W-1:0] clr_idx,
   input  logic [REG_IDX_W-1:0] q_rn,
   input  logic [REG_IDX_W-1:0] q_rm,
   input  logic [REG_IDX_W-1:0] q_rs,
   input  logic [REG_IDX_W-1:0] q_rd,
   output logic                 pend_rn,
   output logic                 pend_rm,
   output logic                 pend_rs,
   output logic                 pend_rd
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Clear first, then set, so the set wins on a collision. Clearing an
   // already-clear bit is harmless.
   always_comb begin
      pending_d = pending_q;
      if (clr_en) pending_d[clr_idx] = 1'b0;
      if (set_en) pending_d[set_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   // Queries see registered state only; same-cycle writeback forwarding is
   // handled by the caller.
   assign pend_rn = pending_q[q_rn];
   assign pend_rm = pending_q[q_rm];
   assign pend_rs = pending_q[q_rs];
   assign pend_rd = pending_q[q_rd];

endmodule

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit
//   Reads source operands for a decoded instruction, blocks on RAW and WAW
//   hazards against a register scoreboard, forwards same-cycle writeback
//   data, and hands the operands to execute through a one-entry output
//   register with valid/ready flow control.
//   Ports:
//     CLK, RST                  : clock, synchronous active-high reset
//     in_valid / in_ready       : decoded-instruction handshake
//     in_rn/in_rm/in_rs (+use)  : source specifiers and read enables
//     in_rd, in_wr_rd           : destination and write intent
//     SA/SB/SD, PA/PB/PD        : register-file read selects and data
//     wb_valid/wb_reg/wb_data   : writeback (clears pending, feeds bypass)
//     out_valid / out_ready     : handshake to execute
//     out_a/out_b/out_d/out_rd/out_wr : registered operand bundle
//     stall_cnt                 : saturating count of hazard-stall cycles
module operand_fetch_unit
   import operand_fetch_unit_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [REG_IDX_W-1:0] in_rn,
   input  logic [REG_IDX_W-1:0] in_rm,
   input  logic [REG_IDX_W-1:0] in_rs,
   input  logic                 in_use_rn,
   input  logic                 in_use_rm,
   input  logic                 in_use_rs,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic                 in_wr_rd,
   output logic [REG_IDX_W-1:0] SA,
   output logic [REG_IDX_W-1:0] SB,
   output logic [REG_IDX_W-1:0] SD,
   input  logic [DATA_W-1:0]    PA,
   input  logic [DATA_W-1:0]    PB,
   input  logic [DATA_W-1:0]    PD,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_reg,
   input  logic [DATA_W-1:0]    wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_a,
   output logic [DATA_W-1:0]    out_b,
   output logic [DATA_W-1:0]    out_d,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic                 out_wr,
   output logic [STALL_W-1:0]   stall_cnt
);

   // Register-file selects come straight from the decoded specifiers so the
   // read data is available in the same cycle.
   assign SA = in_rn;
   assign SB = in_rm;
   assign SD = in_rs;

   logic pend_rn, pend_rm, pend_rs, pend_rd;
   logic wb_hit_rn, wb_hit_rm, wb_hit_rs, wb_hit_rd;
   logic haz_rn, haz_rm, haz_rs, haz_waw, hazard;
   logic space, issue;

   out_item_t            out_item_q, out_item_d;
   logic                 out_valid_q, out_valid_d;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

   reg_scoreboard u_sb (
      .clk     (CLK),
      .rst     (RST),
      .set_en  (issue && in_wr_rd),
      .set_idx (in_rd),
      .clr_en  (wb_valid),
      .clr_idx (wb_reg),
      .q_rn    (in_rn),
      .q_rm    (in_rm),
      .q_rs    (in_rs),
      .q_rd    (in_rd),
      .pend_rn (pend_rn),
      .pend_rm (pend_rm),
      .pend_rs (pend_rs),
      .pend_rd (pend_rd)
   );

   // A pending register whose writeback lands this cycle is not a hazard:
   // its value is forwarded (sources) or it completes now (WAW).
   assign wb_hit_rn = wb_valid && (wb_reg == in_rn);
   assign wb_hit_rm = wb_valid && (wb_reg == in_rm);
   assign wb_hit_rs = wb_valid && (wb_reg == in_rs);
   assign wb_hit_rd = wb_valid && (wb_reg == in_rd);

   assign haz_rn  = in_use_rn && pend_rn && !wb_hit_rn;
   assign haz_rm  = in_use_rm && pend_rm && !wb_hit_rm;
   assign haz_rs  = in_use_rs && pend_rs && !wb_hit_rs;
   assign haz_waw = in_wr_rd  && pend_rd && !wb_hit_rd;
   assign hazard  = haz_rn || haz_rm || haz_rs || haz_waw;

   // The output register can accept when empty or draining this cycle.
   assign space    = !out_valid_q || out_ready;
   assign in_ready = space && !hazard && !RST;
   assign issue    = in_valid && in_ready;

   always_comb begin
      out_item_d  = out_item_q;
      out_valid_d = out_valid_q;
      stall_cnt_d = stall_cnt_q;

      if (issue) begin
         out_item_d.a  = bypass_sel(in_use_rn, wb_hit_rn, wb_data, PA);
         out_item_d.b  = bypass_sel(in_use_rm, wb_hit_rm, wb_data, PB);
         out_item_d.d  = bypass_sel(in_use_rs, wb_hit_rs, wb_data, PD);
         out_item_d.rd = in_rd;
         out_item_d.wr = in_wr_rd;
         out_valid_d   = 1'b1;
      end else if (out_ready) begin
         // Data is left as is; only the valid drops.
         out_valid_d   = 1'b0;
      end

      if (in_valid && hazard && (stall_cnt_q != {STALL_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_item_q  <= '0;
         out_valid_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         out_item_q  <= out_item_d;
         out_valid_q <= out_valid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_item_q.a;
   assign out_b     = out_item_q.b;
   assign out_d     = out_item_q.d;
   assign out_rd    = out_item_q.rd;
   assign out_wr    = out_item_q.wr;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit
//   Directed scenarios followed by random traffic. The stimulus process keeps
//   a set of outstanding destination registers and a queue of expected
//   operand bundles; a monitor process compares every presented output
//   against the queue head and pops on transfer.
module tb_operand_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid, in_ready;
   logic [3:0]  in_rn, in_rm, in_rs, in_rd;
   logic        in_use_rn, in_use_rm, in_use_rs, in_wr_rd;
   logic [3:0]  SA, SB, SD;
   logic [31:0] PA, PB, PD;
   logic        wb_valid;
   logic [3:0]  wb_reg;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_a, out_b, out_d;
   logic [3:0]  out_rd;
   logic        out_wr;
   logic [15:0] stall_cnt;

   always #5 CLK = ~CLK;

   operand_fetch_unit dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rn(in_rn), .in_rm(in_rm), .in_rs(in_rs),
      .in_use_rn(in_use_rn), .in_use_rm(in_use_rm), .in_use_rs(in_use_rs),
      .in_rd(in_rd), .in_wr_rd(in_wr_rd),
      .SA(SA), .SB(SB), .SD(SD),
      .PA(PA), .PB(PB), .PD(PD),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_d(out_d),
      .out_rd(out_rd), .out_wr(out_wr),
      .stall_cnt(stall_cnt)
   );

   typedef struct packed {
      logic        rst;
      logic        in_valid;
      logic [3:0]  rn, rm, rs;
      logic        use_rn, use_rm, use_rs;
      logic [3:0]  rd;
      logic        wr_rd;
      logic [31:0] pa, pb, pd;
      logic        wb_valid;
      logic [3:0]  wb_reg;
      logic [31:0] wb_data;
      logic        out_ready;
   } stim_t;

   typedef struct {
      logic [31:0] a, b, d;
      logic [3:0]  rd;
      logic        wr;
      int          cyc;
   } item_t;

   item_t       q[$];
   bit          pend[16];
   logic [15:0] m_stall;
   bit          known = 0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.out_ready = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] opnd(input bit use_src, input logic [3:0] r,
                                        input logic [31:0] rf, input stim_t s);
      return (use_src && s.wb_valid && s.wb_reg == r) ? s.wb_data : rf;
   endfunction

   function automatic bit src_blocked(input bit use_src, input logic [3:0] r, input stim_t s);
      return use_src && pend[r] && !(s.wb_valid && s.wb_reg == r);
   endfunction

   // One clock of stimulus plus the reference model's view of that cycle.
   task automatic step(input stim_t s);
      bit    haz, exp_rdy, issue;
      item_t it;
      @(negedge CLK);
      cyc++;
      RST = s.rst;       in_valid = s.in_valid;
      in_rn = s.rn;      in_rm = s.rm;        in_rs = s.rs;
      in_use_rn = s.use_rn; in_use_rm = s.use_rm; in_use_rs = s.use_rs;
      in_rd = s.rd;      in_wr_rd = s.wr_rd;
      PA = s.pa;         PB = s.pb;           PD = s.pd;
      wb_valid = s.wb_valid; wb_reg = s.wb_reg; wb_data = s.wb_data;
      out_ready = s.out_ready;
      #1;
      haz = src_blocked(s.use_rn, s.rn, s) || src_blocked(s.use_rm, s.rm, s) ||
            src_blocked(s.use_rs, s.rs, s) || src_blocked(s.wr_rd, s.rd, s);
      exp_rdy = !s.rst && !haz && (q.size() == 0 || s.out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("selects", {SA, SB, SD}, {s.rn, s.rm, s.rs});
      if (known) chk("stall_cnt", stall_cnt, m_stall);
      if (s.rst) begin
         pend = '{default: 0};
         q.delete();
         m_stall = 16'd0;
         known = 1;
      end else begin
         issue = s.in_valid && exp_rdy;
         if (s.in_valid && haz && m_stall != 16'hFFFF) m_stall++;
         // A writeback retires its register; a new writer re-marks it.
         if (s.wb_valid) pend[s.wb_reg] = 0;
         if (issue) begin
            it.a   = opnd(s.use_rn, s.rn, s.pa, s);
            it.b   = opnd(s.use_rm, s.rm, s.pb, s);
            it.d   = opnd(s.use_rs, s.rs, s.pd, s);
            it.rd  = s.rd;
            it.wr  = s.wr_rd;
            it.cyc = cyc;
            q.push_back(it);
            if (s.wr_rd) pend[s.rd] = 1;
         end
      end
   endtask

   // Monitor: runs after the stimulus has settled each cycle. Items issued in
   // the current cycle are not yet visible on the outputs.
   initial begin
      bit avail;
      forever begin
         @(negedge CLK);
         #2;
         if (known && !RST) begin
            avail = (q.size() != 0) && (q[0].cyc < cyc);
            chk("out_valid", out_valid, avail);
            if (avail && out_valid) begin
               chk("out_a",  out_a,  q[0].a);
               chk("out_b",  out_b,  q[0].b);
               chk("out_d",  out_d,  q[0].d);
               chk("out_rd", out_rd, q[0].rd);
               chk("out_wr", out_wr, q[0].wr);
            end
            if (avail && out_ready) void'(q.pop_front());
         end
      end
   end

   function automatic stim_t rand_stim();
      stim_t s;
      int    pl[$];
      s.rst       = ($urandom_range(0, 599) == 0);
      s.in_valid  = ($urandom_range(0, 9) < 7);
      s.rn        = 4'($urandom_range(0, 15));
      s.rm        = 4'($urandom_range(0, 15));
      s.rs        = 4'($urandom_range(0, 15));
      s.use_rn    = $urandom_range(0, 1);
      s.use_rm    = $urandom_range(0, 1);
      s.use_rs    = ($urandom_range(0, 3) == 0);
      s.rd        = 4'($urandom_range(0, 15));
      s.wr_rd     = ($urandom_range(0, 9) < 6);
      s.pa        = $urandom;
      s.pb        = $urandom;
      s.pd        = $urandom;
      s.wb_valid  = ($urandom_range(0, 9) < 5);
      s.wb_data   = $urandom;
      s.out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 16; i++) if (pend[i]) pl.push_back(i);
      if (pl.size() != 0 && $urandom_range(0, 3) != 0)
         s.wb_reg = 4'(pl[$urandom_range(0, pl.size() - 1)]);
      else
         s.wb_reg = 4'($urandom_range(0, 15));
      return s;
   endfunction

   initial begin
      stim_t s;

      // Reset and reset-state values.
      s = idle(); s.rst = 1;
      step(s); step(s);
      s = idle(); s.out_ready = 0;
      step(s);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_abd", {out_a, out_b, out_d}, 96'd0);
      chk("rst_out_rd_wr", {out_rd, out_wr}, 5'd0);
      chk("rst_stall", stall_cnt, 16'd0);

      // No hazard: R1=3, R2=7.
      s = idle(); s.in_valid = 1; s.rn = 1; s.use_rn = 1; s.rm = 2; s.use_rm = 1;
      s.pa = 32'd3; s.pb = 32'd7;
      step(s);
      s = idle();
      step(s);
      chk("nohaz_out", {out_valid, out_a, out_b}, {1'b1, 32'd3, 32'd7});

      // RAW on R10, resolved by writeback with bypass.
      s = idle(); s.in_valid = 1; s.rd = 10; s.wr_rd = 1;
      step(s);
      s = idle(); s.in_valid = 1; s.rn = 10; s.use_rn = 1; s.pa = 32'd99;
      step(s); step(s); step(s);
      chk("raw_stall_ready", in_ready, 1'b0);
      s.wb_valid = 1; s.wb_reg = 10; s.wb_data = 32'd16;
      step(s);
      chk("raw_stall_cnt", stall_cnt, 16'd3);
      s = idle();
      step(s);
      chk("raw_bypass", {out_valid, out_a}, {1'b1, 32'd16});

      // WAW on R4; issue coinciding with R4 writeback leaves R4 pending.
      s = idle(); s.in_valid = 1; s.rd = 4; s.wr_rd = 1;
      step(s); step(s); step(s);
      s.wb_valid = 1; s.wb_reg = 4; s.wb_data = 32'h44;
      step(s);
      s = idle(); s.in_valid = 1; s.rn = 4; s.use_rn = 1;
      step(s);
      chk("waw_still_pending", in_ready, 1'b0);
      s.wb_valid = 1; s.wb_reg = 4; s.wb_data = 32'h1234;
      step(s);
      step(idle());

      // Backpressure: hold for three cycles, then one transfer and next issue.
      s = idle(); s.out_ready = 0; s.in_valid = 1; s.rn = 3; s.use_rn = 1; s.pa = 32'hA5;
      step(s);
      s.rn = 5; s.pa = 32'h11;
      step(s); step(s); step(s);
      chk("bp_hold", {out_valid, out_a, in_ready}, {1'b1, 32'hA5, 1'b0});
      s.out_ready = 1;
      step(s);
      s = idle();
      step(s);
      chk("bp_next", {out_valid, out_a}, {1'b1, 32'h11});
      step(s);

      // Reset with R5 pending and an item held at the output.
      s = idle(); s.out_ready = 0; s.in_valid = 1; s.rd = 5; s.wr_rd = 1; s.pa = 32'h55;
      step(s);
      s = idle(); s.out_ready = 0;
      step(s);
      s.rst = 1;
      step(s);
      s = idle(); s.in_valid = 1; s.rn = 5; s.use_rn = 1; s.pa = 32'd77;
      step(s);
      chk("rst_mid_zero", {out_valid, out_a, out_rd, out_wr, stall_cnt}, 54'd0);
      chk("rst_mid_issue", in_ready, 1'b1);
      step(idle());

      // Random traffic.
      for (int i = 0; i < 4000; i++) step(rand_stim());

      // Drain: let outstanding writebacks and outputs clear.
      for (int r = 0; r < 16; r++) begin
         s = idle(); s.wb_valid = 1; s.wb_reg = 4'(r);
         step(s);
      end
      step(idle()); step(idle());

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/operand_fetch_unit.md
OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 SHALL have clock CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have reset RST, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 bit each: decoded-instruction handshake.
REQ-004 SHALL have in_rn, in_rm, in_rs, input, 4 bits each: source register specifiers.
REQ-005 SHALL have in_use_rn, in_use_rm, in_use_rs, input, 1 bit each: the matching source is actually read.
REQ-006 SHALL have in_rd, input, 4 bits, plus in_wr_rd, input, 1 bit: destination register and its write intent.
REQ-007 SHALL have SA, SB, SD, output, 4 bits each: register-file read selects, driven from in_rn, in_rm and in_rs.
REQ-008 SHALL have PA, PB, PD, input, 32 bits each: register-file read data, same cycle as the selects.
REQ-009 SHALL have wb_valid, input, 1 bit; wb_reg, input, 4 bits; wb_data, input, 32 bits: writeback, which also drives register-file C/PC/RFLd.
REQ-010 SHALL have out_valid/out_ready, output/input, 1 bit each: handshake to the execute stage.
REQ-011 SHALL have out_a, out_b, out_d, output, 32 bits each; out_rd, output, 4 bits; out_wr, output, 1 bit.
REQ-012 SHALL have stall_cnt, output, 16 bits: hazard-stall cycle counter.

Function
REQ-013 SHALL keep a 16-bit pending scoreboard, one bit per register R0..R15.
REQ-014 SHALL raise a source hazard when a used source has its pending bit set and is not being written this cycle (wb_valid=1 with wb_reg equal to that source).
REQ-015 SHALL raise a WAW hazard when in_wr_rd=1 and pending[in_rd]=1, unless wb_valid=1 and wb_reg=in_rd.
REQ-016 SHALL define space = !out_valid || out_ready.
REQ-017 SHALL drive in_ready = space && no hazard, combinationally; issue = in_valid && in_ready.
REQ-018 SHALL bypass data: each used source equal to wb_reg while wb_valid=1 takes wb_data; otherwise it takes PA, PB or PD.
REQ-019 SHALL, on issue, register the operands, in_rd and in_wr_rd into the out_* registers and set out_valid=1 on the next edge (latency 1 cycle).
REQ-020 SHALL clear out_valid when out_ready=1 and no issue occurs.
REQ-021 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL set pending[in_rd] on issue when in_wr_rd=1.
REQ-023 SHALL clear pending[wb_reg] when wb_valid=1.
REQ-024 SHALL let the set win when set and clear target the same register in the same cycle.
REQ-025 SHALL ignore wb_valid for a register whose pending bit is clear: no error, bit stays 0.
REQ-026 SHALL increment stall_cnt each cycle where in_valid=1 and a hazard exists, saturating at 0xFFFF.
REQ-027 SHALL treat R15 like any other register; no special PC handling.

Reset
REQ-028 SHALL, when RST=1 at a clock edge, clear the scoreboard, out_valid, out_a, out_b, out_d, out_rd, out_wr and stall_cnt to 0.
REQ-029 SHALL discard an in-flight output item and all pending bits on reset mid-operation.
REQ-030 SHALL hold in_ready=0 during any cycle in which RST=1.

Structure
REQ-031 SHALL take NUM_REGS=16, REG_IDX_W=4, DATA_W=32 and PC_IDX=15 from the shared CPU package.
REQ-032 SHALL put the scoreboard (set/clear/query, set-wins rule) in one sub-module, reg_scoreboard.

Verification
REQ-033 SHALL verify no hazard: issue rn=1 (PA=3) and rm=2 (PB=7) -> next cycle out_valid=1, out_a=3, out_b=7.
REQ-034 SHALL verify RAW stall: issue a write to R10, then read R10 -> in_ready=0 and stall_cnt increments; wb_valid with wb_reg=10 and wb_data=16 -> issue that same cycle with out_a=16 (bypass).
REQ-035 SHALL verify WAW: R4 pending plus a new write to R4 -> stall until wb_reg=4; simultaneous issue and wb on R4 -> pending[4] ends at 1.
REQ-036 SHALL verify backpressure: out_ready=0 for 3 cycles -> out_* held, in_ready=0; out_ready=1 -> one transfer and the next item issues.
REQ-037 SHALL verify reset mid-operation: RST=1 with pending bits set and out_valid=1 -> next cycle all zero, and a read of a previously pending register issues immediately.
